mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access with a small FSM and drives the memory handshake.
- Raises a pipeline-freeze signal, consumed by the hazard logic alongside the data-hazard stall, until the pending access completes.
- Handles jump flush of an in-flight fetch.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory
// between instruction fetch (IF) and load/store (MEM). Loads and stores win
// over fetches because they belong to the older instruction.
// Optional feature macro: MEM_PORT_ARBITER_PERF_EN adds stall/conflict counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; arbitrate d_req over if_req
// FETCH  | instruction read in flight, waiting for mem_ready
// DATA   | load/store in flight, waiting for mem_ready
// RESP   | one response cycle: pulse if_valid/d_done, pipeline advances
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_stall
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_mem_en, w_mem_en_nxt;
    logic               r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]  r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0]  r_d_rdata, w_d_rdata_nxt;
    logic               r_from_data, w_from_data_nxt;
    logic               r_discard, w_discard_nxt;
    logic               w_d_req;

    // A simultaneous load+store request is a store: mem_we follows d_we.
    assign w_d_req = d_re | d_we;

    // State and access registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_from_data <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_from_data <= w_from_data_nxt;
            r_discard   <= w_discard_nxt;
        end
    end

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_from_data_nxt = r_from_data;
        w_discard_nxt   = r_discard;
        case (r_state)
            S_IDLE: begin
                if (w_d_req) begin
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_mem_we_nxt    = d_we;
                    w_mem_en_nxt    = 1'b1;
                    w_from_data_nxt = 1'b1;
                    w_state_nxt     = S_DATA;
                end else if (if_req && !flush) begin
                    w_mem_addr_nxt  = if_addr;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_en_nxt    = 1'b1;
                    w_from_data_nxt = 1'b0;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_FETCH: begin
                // The memory cannot abort, so a flushed fetch runs to completion
                // and only its if_valid pulse is dropped.
                if (flush) begin
                    w_discard_nxt = 1'b1;
                end
                if (mem_ready) begin
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_if_rdata_nxt = mem_rdata;
                    w_state_nxt    = S_RESP;
                end
            end
            S_DATA: begin
                if (mem_ready) begin
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_d_rdata_nxt = mem_rdata;
                    end
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_discard_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

    assign d_done   = (r_state == S_RESP) & r_from_data;
    assign if_valid = (r_state == S_RESP) & ~r_from_data & ~r_discard & ~flush;

    // Low in RESP so the pipeline advances exactly once per access; a fetch
    // request alongside a jump in IDLE is not issued, so it must not freeze.
    assign mem_stall = (w_d_req | if_req) & (r_state != S_RESP)
                     & ~((r_state == S_IDLE) & flush & ~w_d_req);

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_conflict_cycles;

    // Free-running, wrapping event counters for stall and arbitration loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles    <= '0;
            r_conflict_cycles <= '0;
        end else begin
            if (mem_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((r_state == S_IDLE) && w_d_req && if_req) begin
                r_conflict_cycles <= r_conflict_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign conflict_cycles = r_conflict_cycles;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: variable-latency memory model, cycle-table
// stimulus, and a scoreboard of expected if_valid/d_done responses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_re, d_we, flush;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        mem_en, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, d_done, mem_stall;
    logic [15:0] if_rdata, d_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] stall_cycles, conflict_cycles;
`endif

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_stall(mem_stall)
`ifdef MEM_PORT_ARBITER_PERF_EN
        , .stall_cycles(stall_cycles), .conflict_cycles(conflict_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_data;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tb_stall_cnt = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [15:0] mem_arr [0:65535];

    function automatic logic [15:0] f_mem(input logic [15:0] a);
        return (a << 3) ^ 16'h3C96 ^ {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory: mem_ready on the mem_lat-th cycle mem_en is seen high.
    always @(negedge clk) begin
        if (mem_en) begin
            mem_cnt   = mem_cnt + 1;
            mem_ready = (mem_cnt == mem_lat);
            mem_rdata = mem_arr[mem_addr];
            if (mem_ready && mem_we) mem_arr[mem_addr] = mem_wdata;
        end else begin
            mem_cnt   = 0;
            mem_ready = 1'b0;
            mem_rdata = 16'h0000;
        end
    end

    // Response monitor: every pulse must match the oldest expected response.
    always @(negedge clk) begin
        #3;
        if (rst_n && (if_valid || d_done)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pulse", {30'd0, if_valid, d_done}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_kind", 32'(d_done), 32'(mon_e.is_data));
                chk("sb_data", 32'(d_done ? d_rdata : if_rdata), 32'(mon_e.data));
            end
        end
    end

    // One cycle: drive {if_req,d_re,d_we,flush} after the falling edge, then check.
    task automatic cyc(input string tag, input logic [3:0] fl, input logic [15:0] ia,
                       input logic [15:0] da, input logic [15:0] dw,
                       input logic x_en, input logic x_we, input logic [15:0] x_addr,
                       input logic [15:0] x_wdata, input logic x_stall);
        @(negedge clk); #1;
        if_req = fl[3]; d_re = fl[2]; d_we = fl[1]; flush = fl[0];
        if_addr = ia; d_addr = da; d_wdata = dw;
        #1;
        chk({tag, "_en"}, 32'(mem_en), 32'(x_en));
        chk({tag, "_we"}, 32'(mem_we), 32'(x_we));
        if (x_en) chk({tag, "_addr"}, 32'(mem_addr), 32'(x_addr));
        if (x_en && x_we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(x_wdata));
        chk({tag, "_stall"}, 32'(mem_stall), 32'(x_stall));
        if (mem_stall) tb_stall_cnt++;
    endtask

    function automatic exp_t mk(input logic is_data, input logic [15:0] d);
        exp_t e;
        e.is_data = is_data;
        e.data    = d;
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = f_mem(16'(i));
        mem_arr[16'h0010] = 16'hA5A5;
        if_req = 0; d_re = 0; d_we = 0; flush = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_pulses", {30'd0, if_valid, d_done}, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fetch 0x0010, ready on the 3rd busy cycle.
        mem_lat = 3;
        sb_q.push_back(mk(1'b0, 16'hA5A5));
        cyc("t1c0", 4'b1000, 16'h0010, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 3; k++) cyc("t1busy", 4'b1000, 16'h0010, 0, 0, 1, 0, 16'h0010, 0, 1);
        cyc("t1resp", 4'b1000, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1idle", 4'b0000, 16'h0010, 0, 0, 0, 0, 0, 0, 0);

        // Load and fetch collide: load first, then fetch two cycles after d_done.
        mem_lat = 2;
        sb_q.push_back(mk(1'b1, f_mem(16'h0200)));
        sb_q.push_back(mk(1'b0, f_mem(16'h0012)));
        cyc("t2c0", 4'b1100, 16'h0012, 16'h0200, 0, 0, 0, 0, 0, 1);
        cyc("t2d1", 4'b1100, 16'h0012, 16'h0200, 0, 1, 0, 16'h0200, 0, 1);
        cyc("t2d2", 4'b1100, 16'h0012, 16'h0200, 0, 1, 0, 16'h0200, 0, 1);
        cyc("t2dresp", 4'b1100, 16'h0012, 16'h0200, 0, 0, 0, 0, 0, 0);
        cyc("t2idle", 4'b1000, 16'h0012, 16'h0200, 0, 0, 0, 0, 0, 1);
        cyc("t2f1", 4'b1000, 16'h0012, 16'h0200, 0, 1, 0, 16'h0012, 0, 1);
        cyc("t2f2", 4'b1000, 16'h0012, 16'h0200, 0, 1, 0, 16'h0012, 0, 1);
        cyc("t2fresp", 4'b1000, 16'h0012, 16'h0200, 0, 0, 0, 0, 0, 0);
        cyc("t2end", 4'b0000, 16'h0012, 16'h0200, 0, 0, 0, 0, 0, 0);
`ifdef MEM_PORT_ARBITER_PERF_EN
        @(negedge clk); #1;
        chk("perf_conflict", conflict_cycles, 32'd1);
        chk("perf_stall", stall_cycles, 32'(tb_stall_cnt));
`endif

        // Store with immediate ready; d_rdata keeps the previous load value.
        mem_lat = 1;
        sb_q.push_back(mk(1'b1, f_mem(16'h0200)));
        cyc("t3c0", 4'b0010, 0, 16'h0300, 16'h1234, 0, 0, 0, 0, 1);
        cyc("t3st", 4'b0010, 0, 16'h0300, 16'h1234, 1, 1, 16'h0300, 16'h1234, 1);
        cyc("t3resp", 4'b0010, 0, 16'h0300, 16'h1234, 0, 0, 0, 0, 0);
        cyc("t3end", 4'b0000, 0, 16'h0300, 16'h1234, 0, 0, 0, 0, 0);

        // d_re and d_we together behave as a store; read it back.
        sb_q.push_back(mk(1'b1, f_mem(16'h0200)));
        cyc("t3bc0", 4'b0110, 0, 16'h0304, 16'hBEEF, 0, 0, 0, 0, 1);
        cyc("t3bst", 4'b0110, 0, 16'h0304, 16'hBEEF, 1, 1, 16'h0304, 16'hBEEF, 1);
        cyc("t3bresp", 4'b0110, 0, 16'h0304, 16'hBEEF, 0, 0, 0, 0, 0);
        cyc("t3bend", 4'b0000, 0, 16'h0304, 16'hBEEF, 0, 0, 0, 0, 0);
        mem_lat = 2;
        sb_q.push_back(mk(1'b1, 16'hBEEF));
        cyc("t3lc0", 4'b0100, 0, 16'h0304, 0, 0, 0, 0, 0, 1);
        cyc("t3l1", 4'b0100, 0, 16'h0304, 0, 1, 0, 16'h0304, 0, 1);
        cyc("t3l2", 4'b0100, 0, 16'h0304, 0, 1, 0, 16'h0304, 0, 1);
        cyc("t3lresp", 4'b0100, 0, 16'h0304, 0, 0, 0, 0, 0, 0);
        cyc("t3lend", 4'b0000, 0, 16'h0304, 0, 0, 0, 0, 0, 0);

        // Flush during FETCH: access completes, no if_valid, if_rdata updated.
        mem_lat = 3;
        cyc("t4ac0", 4'b1000, 16'h0020, 0, 0, 0, 0, 0, 0, 1);
        cyc("t4af1", 4'b1001, 16'h0020, 0, 0, 1, 0, 16'h0020, 0, 1);
        cyc("t4af2", 4'b1000, 16'h0020, 0, 0, 1, 0, 16'h0020, 0, 1);
        cyc("t4af3", 4'b1000, 16'h0020, 0, 0, 1, 0, 16'h0020, 0, 1);
        cyc("t4aresp", 4'b1000, 16'h0020, 0, 0, 0, 0, 0, 0, 0);
        chk("t4a_if_valid", 32'(if_valid), 32'd0);
        chk("t4a_if_rdata", 32'(if_rdata), 32'(f_mem(16'h0020)));
        cyc("t4aend", 4'b0000, 16'h0020, 0, 0, 0, 0, 0, 0, 0);

        // Flush in IDLE with only a fetch pending: no stall, no issue.
        mem_lat = 1;
        sb_q.push_back(mk(1'b0, f_mem(16'h0024)));
        cyc("t4bc0", 4'b1001, 16'h0024, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4bc1", 4'b1000, 16'h0024, 0, 0, 0, 0, 0, 0, 1);
        cyc("t4bf", 4'b1000, 16'h0024, 0, 0, 1, 0, 16'h0024, 0, 1);
        cyc("t4bresp", 4'b1000, 16'h0024, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4bend", 4'b0000, 16'h0024, 0, 0, 0, 0, 0, 0, 0);

        // Flush in RESP suppresses if_valid.
        cyc("t4cc0", 4'b1000, 16'h0028, 0, 0, 0, 0, 0, 0, 1);
        cyc("t4cf", 4'b1000, 16'h0028, 0, 0, 1, 0, 16'h0028, 0, 1);
        cyc("t4cresp", 4'b1001, 16'h0028, 0, 0, 0, 0, 0, 0, 0);
        chk("t4c_if_valid", 32'(if_valid), 32'd0);
        cyc("t4cend", 4'b0000, 16'h0028, 0, 0, 0, 0, 0, 0, 0);

        // Flush during DATA has no effect.
        mem_lat = 2;
        sb_q.push_back(mk(1'b1, f_mem(16'h0400)));
        cyc("t4dc0", 4'b0100, 0, 16'h0400, 0, 0, 0, 0, 0, 1);
        cyc("t4dd1", 4'b0101, 0, 16'h0400, 0, 1, 0, 16'h0400, 0, 1);
        cyc("t4dd2", 4'b0100, 0, 16'h0400, 0, 1, 0, 16'h0400, 0, 1);
        cyc("t4dresp", 4'b0100, 0, 16'h0400, 0, 0, 0, 0, 0, 0);
        cyc("t4dend", 4'b0000, 0, 16'h0400, 0, 0, 0, 0, 0, 0);

        // Reset mid-DATA: outputs drop without a clock edge, then a clean fetch.
        mem_lat = 5;
        cyc("t5c0", 4'b0100, 0, 16'h0500, 0, 0, 0, 0, 0, 1);
        cyc("t5d1", 4'b0100, 0, 16'h0500, 0, 1, 0, 16'h0500, 0, 1);
        @(negedge clk); #1;
        rst_n = 1'b0; d_re = 1'b0;
        #1;
        chk("t5_rst_en", 32'(mem_en), 32'd0);
        chk("t5_rst_stall", 32'(mem_stall), 32'd0);
        chk("t5_rst_d_rdata", 32'(d_rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tb_stall_cnt = 0;
        mem_lat = 2;
        sb_q.push_back(mk(1'b0, f_mem(16'h0030)));
        cyc("t5fc0", 4'b1000, 16'h0030, 0, 0, 0, 0, 0, 0, 1);
        cyc("t5f1", 4'b1000, 16'h0030, 0, 0, 1, 0, 16'h0030, 0, 1);
        cyc("t5f2", 4'b1000, 16'h0030, 0, 0, 1, 0, 16'h0030, 0, 1);
        cyc("t5fresp", 4'b1000, 16'h0030, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5fend", 4'b0000, 16'h0030, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk); #4;
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("perf_conflict_after_rst", conflict_cycles, 32'd0);
        chk("perf_stall_after_rst", stall_cycles, 32'(tb_stall_cnt));
`endif
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
